bc_rx_ram_writer: RTL and testbench

BC_RX_RAM_WRITER -- requirements
Module: bc_rx_ram_writer

---
 rtl/bc_rx_ram_writer.sv | 171 +++++++++++++++++
 tb/tb_bc_rx_ram_writer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bc_rx_ram_writer.sv
// 1553 receive-word writer: packs decoded words into a circular message RAM.
// Each message is a header entry followed by its data entries; the header is
// written last so the consumer only ever sees complete messages through
// COMMIT_PTR.
module bc_rx_ram_writer #(
  parameter int MAX_WORDS = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RX_VALID,
  input  logic [15:0] RX_WORD,
  input  logic        RX_SYNC,
  input  logic        RX_PERR,
  input  logic        RX_MERR,
  input  logic        RX_MSG_END,
  output logic        RX_READY,
  input  logic [9:0]  RD_PTR,
  output logic [9:0]  A_ADDR,
  output logic [39:0] A_DIN,
  output logic        A_WEN,
  output logic [3:0]  A_WBYTE_EN,
  output logic        A_REN,
  output logic [9:0]  COMMIT_PTR,
  output logic        MSG_DONE,
  output logic        OVERFLOW,
  output logic [7:0]  DROP_CNT
);

  typedef enum logic [2:0] {IDLE, DATA, HEADER, COMMIT, DROP} state_t;

  localparam logic [5:0] MAXW = 6'(MAX_WORDS);

  state_t      state, state_n;
  logic [9:0]  wr_ptr, wr_n, hdr_addr, hdr_n, commit_n;
  logic [7:0]  seq, seq_n, drop_n;
  logic [5:0]  cnt, cnt_n;
  logic        trunc, trunc_n, any_p, any_p_n, any_m, any_m_n;
  logic        ovf_n, done_n, wen_n, ready_n;
  logic [9:0]  addr_n;
  logic [39:0] din_n, data_ent;
  logic        acc, room1, room2;
  logic [7:0]  drop_inc;

  assign acc      = RX_VALID && RX_READY;
  assign data_ent = {2'b01, 18'd0, RX_SYNC, RX_MERR, RX_PERR, 1'b0, RX_WORD};
  // One slot stays empty so wr_ptr == RD_PTR always means "empty".
  assign room1    = (wr_ptr + 10'd1) != RD_PTR;
  assign room2    = room1 && ((wr_ptr + 10'd2) != RD_PTR);
  assign drop_inc = (DROP_CNT == 8'hFF) ? DROP_CNT : DROP_CNT + 8'd1;

  assign A_WBYTE_EN = A_WEN ? 4'hF : 4'h0;
  assign A_REN      = 1'b0;

  // Next-state, pointer bookkeeping and RAM write request.
  always_comb begin
    state_n  = state;
    wr_n     = wr_ptr;
    hdr_n    = hdr_addr;
    commit_n = COMMIT_PTR;
    seq_n    = seq;
    cnt_n    = cnt;
    trunc_n  = trunc;
    any_p_n  = any_p;
    any_m_n  = any_m;
    ovf_n    = OVERFLOW;
    drop_n   = DROP_CNT;
    done_n   = 1'b0;
    wen_n    = 1'b0;
    addr_n   = A_ADDR;
    din_n    = A_DIN;
    unique case (state)
      IDLE: if (acc) begin
        if (room2) begin
          hdr_n   = wr_ptr;
          wen_n   = 1'b1;
          addr_n  = wr_ptr + 10'd1;
          din_n   = data_ent;
          wr_n    = wr_ptr + 10'd2;
          cnt_n   = 6'd1;
          trunc_n = 1'b0;
          any_p_n = RX_PERR;
          any_m_n = RX_MERR;
          state_n = RX_MSG_END ? HEADER : DATA;
        end else begin
          ovf_n   = 1'b1;
          drop_n  = drop_inc;
          state_n = RX_MSG_END ? IDLE : DROP;
        end
      end
      DATA: if (acc) begin
        if (cnt >= MAXW) begin
          // Over-length words are flagged, never stored.
          trunc_n = 1'b1;
          any_p_n = any_p | RX_PERR;
          any_m_n = any_m | RX_MERR;
          if (RX_MSG_END) state_n = HEADER;
        end else if (room1) begin
          wen_n   = 1'b1;
          addr_n  = wr_ptr;
          din_n   = data_ent;
          wr_n    = wr_ptr + 10'd1;
          cnt_n   = cnt + 6'd1;
          any_p_n = any_p | RX_PERR;
          any_m_n = any_m | RX_MERR;
          if (RX_MSG_END) state_n = HEADER;
        end else begin
          // Rewind over the partial message; it was never committed.
          wr_n    = hdr_addr;
          ovf_n   = 1'b1;
          drop_n  = drop_inc;
          state_n = RX_MSG_END ? IDLE : DROP;
        end
      end
      HEADER: begin
        wen_n   = 1'b1;
        addr_n  = hdr_addr;
        din_n   = {2'b11, cnt, seq, 5'd0, trunc, any_m, any_p, 16'd0};
        state_n = COMMIT;
      end
      COMMIT: begin
        commit_n = wr_ptr;
        done_n   = 1'b1;
        seq_n    = seq + 8'd1;
        state_n  = IDLE;
      end
      DROP: if (acc && RX_MSG_END) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n != HEADER) && (state_n != COMMIT);
  end

  // State and output registers; reset drops any message in progress.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      hdr_addr   <= '0;
      COMMIT_PTR <= '0;
      seq        <= '0;
      cnt        <= '0;
      trunc      <= 1'b0;
      any_p      <= 1'b0;
      any_m      <= 1'b0;
      OVERFLOW   <= 1'b0;
      DROP_CNT   <= '0;
      MSG_DONE   <= 1'b0;
      A_WEN      <= 1'b0;
      A_ADDR     <= '0;
      A_DIN      <= '0;
      RX_READY   <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_n;
      hdr_addr   <= hdr_n;
      COMMIT_PTR <= commit_n;
      seq        <= seq_n;
      cnt        <= cnt_n;
      trunc      <= trunc_n;
      any_p      <= any_p_n;
      any_m      <= any_m_n;
      OVERFLOW   <= ovf_n;
      DROP_CNT   <= drop_n;
      MSG_DONE   <= done_n;
      A_WEN      <= wen_n;
      A_ADDR     <= addr_n;
      A_DIN      <= din_n;
      RX_READY   <= ready_n;
    end
  end

endmodule

// File: tb/tb_bc_rx_ram_writer.sv
// Directed bench for bc_rx_ram_writer: expected RAM writes and commits are
// queued as each message is driven and checked as the DUT produces them.
module tb_bc_rx_ram_writer;

  logic        CLK = 1'b0;
  logic        RESET, RX_VALID, RX_SYNC, RX_PERR, RX_MERR, RX_MSG_END;
  logic [15:0] RX_WORD;
  logic [9:0]  RD_PTR;
  logic        RX_READY, A_WEN, A_REN, MSG_DONE, OVERFLOW;
  logic [9:0]  A_ADDR, COMMIT_PTR;
  logic [39:0] A_DIN;
  logic [3:0]  A_WBYTE_EN;
  logic [7:0]  DROP_CNT;

  bc_rx_ram_writer #(.MAX_WORDS(33)) dut (
    .CLK(CLK), .RESET(RESET), .RX_VALID(RX_VALID), .RX_WORD(RX_WORD),
    .RX_SYNC(RX_SYNC), .RX_PERR(RX_PERR), .RX_MERR(RX_MERR),
    .RX_MSG_END(RX_MSG_END), .RX_READY(RX_READY), .RD_PTR(RD_PTR),
    .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_WEN(A_WEN), .A_WBYTE_EN(A_WBYTE_EN),
    .A_REN(A_REN), .COMMIT_PTR(COMMIT_PTR), .MSG_DONE(MSG_DONE),
    .OVERFLOW(OVERFLOW), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [9:0] a; logic [39:0] d; } wr_t;
  wr_t        wq[$];
  logic [9:0] cq[$];
  int vectors = 0, miscompares = 0, done_cnt = 0;

  function automatic logic [39:0] dent(logic [15:0] w, logic s, logic m, logic p);
    return {2'b01, 18'd0, s, m, p, 1'b0, w};
  endfunction

  function automatic logic [39:0] hent(logic [5:0] c, logic [7:0] q, logic t, logic m, logic p);
    return {2'b11, c, q, 5'd0, t, m, p, 16'd0};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(int a, logic [39:0] d);
    wq.push_back('{a: 10'(a), d: d});
  endtask

  // Advance one clock, then check any RAM write / commit against the queues.
  task automatic step();
    wr_t e;
    @(posedge CLK); #1;
    chk("byte_en", A_WBYTE_EN, (A_WEN === 1'b1) ? 4'hF : 4'h0);
    if (A_WEN === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", {A_ADDR, A_DIN}, 0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", A_ADDR, e.a);
        chk("wr_data", A_DIN, e.d);
      end
    end
    if (MSG_DONE === 1'b1) begin
      done_cnt++;
      if (cq.size() == 0) chk("unexpected_commit", COMMIT_PTR, 10'h3FF);
      else chk("commit_ptr", COMMIT_PTR, cq.pop_front());
    end
  endtask

  task automatic send(logic [15:0] w, logic s, logic p, logic m, logic e);
    logic ok, acc;
    acc = 1'b0;
    RX_VALID = 1'b1; RX_WORD = w; RX_SYNC = s; RX_PERR = p; RX_MERR = m; RX_MSG_END = e;
    for (int i = 0; i < 50; i++) begin
      ok = RX_READY;
      step();
      if (ok) begin acc = 1'b1; break; end
    end
    chk("word_accepted", acc, 1'b1);
    RX_VALID = 1'b0; RX_MSG_END = 1'b0; RX_PERR = 1'b0; RX_MERR = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (cq.size() != 0 || wq.size() != 0); i++) step();
    chk("commits_drained", cq.size(), 0);
    chk("writes_drained", wq.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a_wen", A_WEN, 1'b0);
    chk("rst_a_addr", A_ADDR, 10'd0);
    chk("rst_a_din", A_DIN, 40'd0);
    chk("rst_a_ren", A_REN, 1'b0);
    chk("rst_msg_done", MSG_DONE, 1'b0);
    chk("rst_rx_ready", RX_READY, 1'b0);
    chk("rst_commit_ptr", COMMIT_PTR, 10'd0);
    chk("rst_overflow", OVERFLOW, 1'b0);
    chk("rst_drop_cnt", DROP_CNT, 8'd0);
  endtask

  initial begin
    int d0, hdr, n;
    logic [15:0] w;
    RESET = 1'b1; RX_VALID = 1'b0; RX_WORD = '0; RX_SYNC = 1'b0; RX_PERR = 1'b0;
    RX_MERR = 1'b0; RX_MSG_END = 1'b0; RD_PTR = '0;
    step(); step();
    chk_reset_outputs();
    RESET = 1'b0;
    step();
    chk("ready_after_reset", RX_READY, 1'b1);

    // Basic 3-word message: header at 0, data at 1..3, commit to 4.
    d0 = done_cnt;
    push_wr(1, dent(16'h0800, 1'b1, 1'b0, 1'b0));
    push_wr(2, dent(16'h1234, 1'b0, 1'b0, 1'b0));
    push_wr(3, dent(16'hABCD, 1'b0, 1'b0, 1'b0));
    push_wr(0, hent(6'd3, 8'd0, 1'b0, 1'b0, 1'b0));
    cq.push_back(10'd4);
    send(16'h0800, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    step(); step();
    chk("t1_single_done", done_cnt - d0, 1);
    chk("t1_commit_hold", COMMIT_PTR, 10'd4);

    // Parity error on word 2: data bit 17 and header bit 16 set, seq 1.
    push_wr(5, dent(16'h0C00, 1'b1, 1'b0, 1'b0));
    push_wr(6, dent(16'h5555, 1'b0, 1'b0, 1'b1));
    push_wr(7, dent(16'h00AA, 1'b0, 1'b0, 1'b0));
    push_wr(4, hent(6'd3, 8'd1, 1'b0, 1'b0, 1'b1));
    cq.push_back(10'd8);
    send(16'h0C00, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h5555, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'h00AA, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset two words into a message: nothing committed, nothing counted.
    d0 = done_cnt;
    push_wr(9,  dent(16'h0D00, 1'b1, 1'b0, 1'b0));
    push_wr(10, dent(16'h7777, 1'b0, 1'b0, 1'b0));
    send(16'h0D00, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h7777, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_writes_seen", wq.size(), 0);
    RESET = 1'b1;
    step();
    chk_reset_outputs();
    RESET = 1'b0;
    step();
    chk("ready_after_mid_reset", RX_READY, 1'b1);
    chk("mid_no_commit", done_cnt - d0, 0);

    // 30 messages of 34 entries each bring wr_ptr from 0 to 1020. The first
    // carries 40 words: 33 stored, truncated flag in its header at address 0.
    for (int m = 0; m < 30; m++) begin
      n   = (m == 0) ? 40 : 33;
      hdr = m * 34;
      for (int k = 0; k < n; k++)
        if (k < 33) push_wr(hdr + 1 + k, dent(16'(m * 64 + k), k == 0, 1'b0, 1'b0));
      push_wr(hdr, hent(6'd33, 8'(m), m == 0, 1'b0, 1'b0));
      cq.push_back(10'(hdr + 34));
      for (int k = 0; k < n; k++)
        send(16'(m * 64 + k), k == 0, 1'b0, 1'b0, k == n - 1);
      drain();
    end
    chk("fill_commit_ptr", COMMIT_PTR, 10'd1020);

    // Wrap: header at 1020, data at 1021..1023 then 0..2, commit to 3.
    RD_PTR = 10'd5;
    for (int k = 0; k < 6; k++)
      push_wr((1021 + k) % 1024, dent(16'hC000 + 16'(k), k == 0, 1'b0, 1'b0));
    push_wr(1020, hent(6'd6, 8'd30, 1'b0, 1'b0, 1'b0));
    cq.push_back(10'd3);
    for (int k = 0; k < 6; k++) send(16'hC000 + 16'(k), k == 0, 1'b0, 1'b0, k == 5);
    drain();
    chk("wrap_commit_ptr", COMMIT_PTR, 10'd3);

    // Overflow: with one slot kept empty, slots 3..5 hold header plus two
    // data words, so the third word is the first that does not fit.
    RD_PTR = 10'd7;
    d0 = done_cnt;
    push_wr(4, dent(16'hD000, 1'b1, 1'b0, 1'b0));
    push_wr(5, dent(16'hD001, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      w = 16'hD000 + 16'(k);
      send(w, k == 0, 1'b0, 1'b0, k == 3);
    end
    step(); step(); step();
    chk("drop_overflow", OVERFLOW, 1'b1);
    chk("drop_cnt", DROP_CNT, 8'd1);
    chk("drop_commit_hold", COMMIT_PTR, 10'd3);
    chk("drop_no_done", done_cnt - d0, 0);
    chk("drop_writes", wq.size(), 0);

    // Consumer catches up; next message reuses the abandoned header slot.
    RD_PTR = 10'd3;
    push_wr(4, dent(16'hE000, 1'b1, 1'b0, 1'b0));
    push_wr(3, hent(6'd1, 8'd31, 1'b0, 1'b0, 1'b0));
    cq.push_back(10'd5);
    send(16'hE000, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    chk("overflow_sticky", OVERFLOW, 1'b1);

    // Final reset clears the sticky flags.
    RESET = 1'b1;
    step();
    chk_reset_outputs();
    RESET = 1'b0;
    step();
    chk("ready_final", RX_READY, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
